// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer.
// Tracks the memory handshake, branch/jump redirects and pipeline stalls.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// BOOT     | first cycle after reset, no request, redirect ignored
// FETCH    | request at pc unless stalled, deliver on imem_ready
// WAIT_MEM | request outstanding, address held until imem_ready
// HOLD     | word returned under stall, deliver once stall drops
// FLUSH    | bubble cycles after a redirect before fetch resumes
module pc_fetch_sequencer #(
    parameter int PC_W      = 9,
    parameter int FLUSH_CYC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    output logic [PC_W-1:0] pc_out,
    output logic            fetch_valid,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            misalign_err,
    output logic            range_err,
    output logic [15:0]     redirect_cnt
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT_MEM,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      flush_cnt_q, flush_cnt_d;
    logic [15:0]     redirect_cnt_q, redirect_cnt_d;

    logic            redirect_acc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] redirect_target;

    assign redirect_acc    = redirect && (state_q != S_BOOT);
    assign pc_inc          = pc_q + PC_W'(4);
    assign redirect_target = {redirect_pc[PC_W-1:2], 2'b00};

    assign imem_addr    = pc_q;
    assign pc_out       = pc_q;
    assign redirect_cnt = redirect_cnt_q;
    assign misalign_err = redirect_acc && (|redirect_pc[1:0]);
    assign range_err    = redirect_acc && (|(redirect_pc >> PC_W));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_BOOT;
            pc_q           <= '0;
            flush_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            flush_cnt_q    <= flush_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        flush_cnt_d    = flush_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        imem_req       = 1'b0;
        fetch_valid    = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!stall) begin
                    imem_req = 1'b1;
                    if (!redirect_acc) begin
                        if (imem_ready) begin
                            fetch_valid = 1'b1;
                            pc_d        = pc_inc;
                        end else begin
                            state_d = S_WAIT_MEM;
                        end
                    end
                end
            end
            S_WAIT_MEM: begin
                // Address must stay stable while the memory is working on it.
                imem_req = 1'b1;
                if (!redirect_acc && imem_ready) begin
                    if (stall) begin
                        state_d = S_HOLD;
                    end else begin
                        fetch_valid = 1'b1;
                        pc_d        = pc_inc;
                        state_d     = S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (!redirect_acc && !stall) begin
                    fetch_valid = 1'b1;
                    pc_d        = pc_inc;
                    state_d     = S_FETCH;
                end
            end
            S_FLUSH: begin
                if (!redirect_acc) begin
                    if (flush_cnt_q <= 3'd1) begin
                        state_d = S_FETCH;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // A redirect overrides whatever the current state decided.
        if (redirect_acc) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pc_d        = redirect_target;
            flush_cnt_d = 3'(FLUSH_CYC);
            state_d     = S_FLUSH;
            if (redirect_cnt_q != 16'hFFFF) begin
                redirect_cnt_d = redirect_cnt_q + 16'd1;
            end
        end
    end

endmodule
